div_result_serializer: RTL and testbench
========================================

Name: div_result_serializer

Overview:
- Sits directly downstream of the unsigned divider stage.
- Accepts one {quotient, remainder} result per valid/ready handshake and emits it as a byte stream (valid/ready, with a last marker) toward the host-facing link.
- Decouples the divider's wide one-shot output from a narrow backpressured byte channel.

Parameters:
- DATA_W, 32, width of the quotient and remainder words; must be a multiple of 8.
- NBYTES, DATA_W/8, bytes per word (derived; not to be overridden).

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
- i_ready, output, 1, block can accept a result this cycle.
- i_valid, input, 1, upstream result valid.
- i_payload_1, input, DATA_W, quotient.
- i_payload_2, input, DATA_W, remainder.
- o_valid, output, 1, o_data holds a valid byte.
- o_ready, input, 1, downstream accepts the byte this cycle.
- o_data, output, 8, current byte.
- o_last, output, 1, high with the final byte of a frame.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, byte counter 0, capture registers 0; outputs i_ready=1, o_valid=0, o_data=0x00, o_last=0.
- Reset asserted mid-frame: the frame is abandoned. No partial bytes are emitted after release.
- States:
  - IDLE: i_ready=1, o_valid=0. On i_valid&&i_ready, capture both words into a {remainder, quotient} shift register, set counter=0, go SEND.
  - SEND: i_ready=0, o_valid=1. o_data = low byte of the shift register.
  - On o_valid&&o_ready in SEND: shift right 8 bits and increment the counter.
  - When the byte accepted is byte 2*NBYTES-1, go IDLE.
- Byte order: quotient LSB-first (bytes 0..NBYTES-1), then remainder LSB-first (bytes NBYTES..2*NBYTES-1).
- o_last=1 only while presenting byte 2*NBYTES-1.
- Latency: first byte valid on the cycle after input acceptance.
  - With o_ready held high, a frame occupies 2*NBYTES consecutive cycles.
  - i_ready rises the cycle after the last byte is accepted, giving a 1-cycle bubble between frames.
- Backpressure: while o_valid=1 and o_ready=0, o_data, o_last and the counter hold stable. o_valid never drops without a transfer.
- Upstream payload changes while in SEND are ignored; only captured values are emitted.
- Divide-by-zero results (both words all ones) are serialized unchanged as 0xFF bytes; no special-casing in the base build.
- Counter width is clog2(2*NBYTES+2). It never wraps, because it is cleared on every capture.

Optional Feature:
- Macro: DIV_SER_FRAME_EN.
- Defined: each frame is wrapped as header byte + the 2*NBYTES data bytes + checksum byte.
  - Header is 0xA5 normally, or 0xE0 when both captured words are all ones (divide-by-zero signature).
  - Checksum is the XOR of all data bytes; the header is excluded.
  - o_last moves to the checksum byte. Frame length is 2*NBYTES+2 bytes.
  - Backpressure rules are unchanged.
- Undefined: no header or checksum; the frame is exactly 2*NBYTES bytes, as described above.

Test Plan:
- Quotient=3, remainder=2, o_ready=1 -> bytes 03 00 00 00 02 00 00 00 on 8 consecutive cycles; o_last only on the 8th; i_ready back high the following cycle.
- Quotient=0x12345678, remainder=0x9ABCDEF0, o_ready toggling 1,0,1,0 -> bytes 78 56 34 12 F0 DE BC 9A; o_data stable on every stalled cycle; no dropped or duplicated bytes.
- Quotient=0xFFFFFFFF, remainder=0xFFFFFFFF -> 8 bytes of 0xFF. With DIV_SER_FRAME_EN: E0, 8x FF, checksum 00; o_last on the checksum.
- Quotient=17, remainder=0 with DIV_SER_FRAME_EN -> A5 11 00 00 00 00 00 00 00 11.
- Hold i_valid=1 with new payload during SEND -> i_ready=0 throughout; the second result is accepted only after o_last transfers; both frames are correct.
- Assert reset after the 3rd byte -> o_valid=0, i_ready=1 immediately. After release, a new result 5/1 produces a clean frame starting with 05.

Source files
------------

// File: rtl/div_result_serializer.sv
// div_result_serializer: turns one {quotient, remainder} divider result into a byte stream.
// Optional framing (header + checksum) is enabled by defining DIV_SER_FRAME_EN.
module div_result_serializer #(
    parameter  int DATA_W = 32,
    localparam int NBYTES = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              i_ready,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_payload_1,
    input  logic [DATA_W-1:0] i_payload_2,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [7:0]        o_data,
    output logic              o_last
);

    localparam int NB2 = 2 * NBYTES;
    localparam int CW  = $clog2(NB2 + 2);
`ifdef DIV_SER_FRAME_EN
    localparam int LAST_I = NB2 + 1;
`else
    localparam int LAST_I = NB2 - 1;
`endif
    localparam logic [CW-1:0] LAST   = LAST_I[CW-1:0];
    localparam logic [CW-1:0] NB2_C  = NB2[CW-1:0];

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [2*DATA_W-1:0] sr;
    logic [CW-1:0]       cnt;
    logic                fire_in;
    logic                fire_out;
    logic                at_last;
    logic                is_data;

`ifdef DIV_SER_FRAME_EN
    logic       hdr_z;
    logic [7:0] csum;
    assign is_data = (cnt != '0) && (cnt <= NB2_C);
`else
    assign is_data = (cnt < NB2_C);
`endif

    assign at_last  = (cnt == LAST);
    assign fire_in  = i_valid && i_ready;
    assign fire_out = o_valid && o_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n = state;
        i_ready = 1'b0;
        o_valid = 1'b0;
        unique case (state)
            IDLE: begin
                i_ready = 1'b1;
                if (i_valid) state_n = SEND;
            end
            SEND: begin
                o_valid = 1'b1;
                if (o_ready && at_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Capture on input handshake, shift and count on each byte transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr    <= '0;
            cnt   <= '0;
`ifdef DIV_SER_FRAME_EN
            hdr_z <= 1'b0;
            csum  <= 8'h00;
`endif
        end else if (fire_in) begin
            sr    <= {i_payload_2, i_payload_1};
            cnt   <= '0;
`ifdef DIV_SER_FRAME_EN
            hdr_z <= &{i_payload_2, i_payload_1};
            csum  <= 8'h00;
`endif
        end else if (fire_out) begin
            cnt <= cnt + 1'b1;
            if (is_data) begin
                sr   <= sr >> 8;
`ifdef DIV_SER_FRAME_EN
                csum <= csum ^ sr[7:0];
`endif
            end
        end
    end

    // Byte mux: header, data or checksum depending on position in frame
    always_comb begin
        o_data = 8'h00;
        o_last = 1'b0;
        if (state == SEND) begin
            o_last = at_last;
`ifdef DIV_SER_FRAME_EN
            if (cnt == '0)   o_data = hdr_z ? 8'hE0 : 8'hA5;
            else if (at_last) o_data = csum;
            else              o_data = sr[7:0];
`else
            o_data = sr[7:0];
`endif
        end
    end

endmodule

// File: tb/tb_div_result_serializer.sv
// Self-checking bench for div_result_serializer.
// Table vectors, hand-written corner sequences and random frames against a byte model.
module tb_div_result_serializer;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          mode;
        logic [7:0]  f;
        logic [7:0]  l;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_ready;
    logic        i_valid;
    logic [31:0] i_payload_1;
    logic [31:0] i_payload_2;
    logic        o_valid;
    logic        o_ready;
    logic [7:0]  o_data;
    logic        o_last;

    int  tests = 0;
    int  fails = 0;
    int  cycles;
    bq_t rx;

    always #5 clk = ~clk;

    div_result_serializer #(.DATA_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .i_ready(i_ready),
        .i_valid(i_valid),
        .i_payload_1(i_payload_1),
        .i_payload_2(i_payload_2),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_data(o_data),
        .o_last(o_last)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic bq_t model(input logic [31:0] q, input logic [31:0] r);
        bq_t        b;
        logic [7:0] x;
        logic [7:0] by;
        x = 8'h00;
        for (int i = 0; i < 4; i++) begin
            by = 8'((q >> (8 * i)) & 32'hFF);
            b.push_back(by);
            x ^= by;
        end
        for (int i = 0; i < 4; i++) begin
            by = 8'((r >> (8 * i)) & 32'hFF);
            b.push_back(by);
            x ^= by;
        end
`ifdef DIV_SER_FRAME_EN
        b.push_front((q == 32'hFFFFFFFF && r == 32'hFFFFFFFF) ? 8'hE0 : 8'hA5);
        b.push_back(x);
`endif
        return b;
    endfunction

    // Called just after a capture edge; returns at the negedge whose
    // following posedge transfers the last requested byte.
    task automatic collect(input logic [31:0] q, input logic [31:0] r,
                           input int mode, input int max_bytes, input bit chk_ir);
        bq_t        exp;
        int         len;
        int         n;
        int         idx;
        int         cyc;
        bit         stalled;
        bit         rdy;
        logic [7:0] pd;
        exp = model(q, r);
        len = exp.size();
        n = (max_bytes > 0) ? max_bytes : len;
        idx = 0;
        cyc = 0;
        stalled = 0;
        pd = 8'h00;
        while (idx < n) begin
            if (cyc >= 200) begin
                chk("frame_timeout", 64'(idx), 64'(n));
                break;
            end
            @(negedge clk);
            cyc++;
            chk("o_valid_in_send", 64'(o_valid), 64'd1);
            if (chk_ir) chk("i_ready_low", 64'(i_ready), 64'd0);
            if (stalled) chk("stall_hold", 64'(o_data), 64'(pd));
            chk("o_data", 64'(o_data), 64'(exp[idx]));
            chk("o_last", 64'(o_last), 64'(idx == len - 1));
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 2) == 1;
            else                rdy = 1'($urandom % 2);
            o_ready = rdy;
            if (o_valid && rdy) begin
                rx.push_back(o_data);
                idx++;
                stalled = 0;
            end else begin
                stalled = o_valid;
                pd = o_data;
            end
        end
        cycles = cyc;
    endtask

    task automatic send(input logic [31:0] q, input logic [31:0] r, input int mode);
        int w;
        int len;
        len = model(q, r).size();
        @(negedge clk);
        w = 0;
        while (i_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("wait_idle", 64'(i_ready), 64'd1);
        i_valid = 1'b1;
        i_payload_1 = q;
        i_payload_2 = r;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_payload_1 = $urandom;
        i_payload_2 = $urandom;
        rx.delete();
        collect(q, r, mode, 0, 1'b1);
        if (mode == 0) chk("frame_cycles", 64'(cycles), 64'(len));
        @(negedge clk);
        chk("bubble_i_ready", 64'(i_ready), 64'd1);
        chk("idle_o_valid", 64'(o_valid), 64'd0);
        chk("rx_len", 64'(rx.size()), 64'(len));
    endtask

    vec_t vecs[4];

    initial begin
        logic [31:0] q;
        logic [31:0] r;
`ifdef DIV_SER_FRAME_EN
        vecs[0] = '{32'd3,        32'd2,        0, 8'hA5, 8'h01};
        vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 1, 8'hA5, 8'h00};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2, 8'hE0, 8'h00};
        vecs[3] = '{32'd17,       32'd0,        0, 8'hA5, 8'h11};
`else
        vecs[0] = '{32'd3,        32'd2,        0, 8'h03, 8'h00};
        vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 1, 8'h78, 8'h9A};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2, 8'hFF, 8'hFF};
        vecs[3] = '{32'd17,       32'd0,        0, 8'h11, 8'h00};
`endif
        reset = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        i_payload_1 = '0;
        i_payload_2 = '0;
        #3;
        chk("rst_i_ready", 64'(i_ready), 64'd1);
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_data", 64'(o_data), 64'd0);
        chk("rst_o_last", 64'(o_last), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_i_ready", 64'(i_ready), 64'd1);
        chk("post_rst_o_valid", 64'(o_valid), 64'd0);

        for (int i = 0; i < 4; i++) begin
            send(vecs[i].q, vecs[i].r, vecs[i].mode);
            chk("first_byte", 64'(rx[0]), 64'(vecs[i].f));
            chk("last_byte", 64'(rx[rx.size() - 1]), 64'(vecs[i].l));
        end

        // New payload held on the input while a frame is in flight
        @(negedge clk);
        i_valid = 1'b1;
        i_payload_1 = 32'h00000064;
        i_payload_2 = 32'h00000007;
        @(posedge clk);
        #1;
        i_payload_1 = 32'hCAFEF00D;
        i_payload_2 = 32'h0BADBEEF;
        rx.delete();
        collect(32'h00000064, 32'h00000007, 1, 0, 1'b1);
        @(negedge clk);
        chk("hold_i_ready_after_last", 64'(i_ready), 64'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        rx.delete();
        collect(32'hCAFEF00D, 32'h0BADBEEF, 0, 0, 1'b1);
        @(negedge clk);
        chk("hold_second_done", 64'(i_ready), 64'd1);

        // Reset after the third byte abandons the frame
        @(negedge clk);
        i_valid = 1'b1;
        i_payload_1 = 32'h12345678;
        i_payload_2 = 32'h9ABCDEF0;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        rx.delete();
        collect(32'h12345678, 32'h9ABCDEF0, 0, 3, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_o_valid", 64'(o_valid), 64'd0);
        chk("midrst_i_ready", 64'(i_ready), 64'd1);
        chk("midrst_o_last", 64'(o_last), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_no_residue", 64'(o_valid), 64'd0);
        send(32'd5, 32'd1, 0);
`ifdef DIV_SER_FRAME_EN
        chk("midrst_first", 64'(rx[0]), 64'hA5);
        chk("midrst_second", 64'(rx[1]), 64'h05);
`else
        chk("midrst_first", 64'(rx[0]), 64'h05);
`endif

        for (int i = 0; i < 20; i++) begin
            q = $urandom;
            r = $urandom;
            if (i % 5 == 0) begin
                q = 32'hFFFFFFFF;
                r = 32'hFFFFFFFF;
            end
            send(q, r, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
